// File: rtl/bypass_bin_decoder_seq_pkg.sv
// Shared types and constants for the sequential CABAC bypass-bin decoder.
// State encoding plus the m_value/byte widths and the range scale shift.
package bypass_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    DONE
  } state_e;

  localparam int SCALE_SHIFT = 7;
  localparam int VAL_W       = 16;
  localparam int BYTE_W      = 8;

endpackage

// File: rtl/bypass_bin_decoder_seq_lane.sv
// One bypass-bin step: shift a bit into m_value and compare against
// the scaled range; the compare uses the full 17-bit shifted value.
module bypass_lane
  import bypass_pkg::*;
(
  input  logic [VAL_W-1:0] val_i,
  input  logic             bit_i,
  input  logic [VAL_W-1:0] scaled_i,
  output logic             bin_o,
  output logic [VAL_W-1:0] val_o
);

  logic [VAL_W:0]   v17;
  logic [VAL_W-1:0] diff;

  assign v17   = {val_i, bit_i};
  assign diff  = v17[VAL_W-1:0] - scaled_i;
  assign bin_o = (v17 >= {1'b0, scaled_i});
  assign val_o = bin_o ? diff : v17[VAL_W-1:0];

endmodule

// File: rtl/bypass_bin_decoder_seq.sv
// Sequential bypass-bin decoder: BINS_PER_CYCLE chained lanes per cycle.
// BYPASS_ALIGNED_EN: range 256 decodes a whole buffered byte per cycle.
module bypass_bin_decoder_seq
  import bypass_pkg::*;
#(
  parameter int MAX_BINS       = 32,
  parameter int BINS_PER_CYCLE = 4,
  parameter int CNT_W          = $clog2(MAX_BINS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic [VAL_W-1:0]    init_value,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CNT_W-1:0]    req_nbins,
  input  logic [8:0]          m_range,
  input  logic                bs_valid,
  input  logic [BYTE_W-1:0]   bs_data,
  output logic                bs_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MAX_BINS-1:0] out_bins,
  output logic [CNT_W-1:0]    out_nbins,
  output logic [VAL_W-1:0]    m_value_out
);

`ifdef BYPASS_ALIGNED_EN
  localparam int NL = BYTE_W;
`else
  localparam int NL = BINS_PER_CYCLE;
`endif
  localparam int RW = (CNT_W > 4) ? CNT_W : 4;

  state_e              state_q, state_d;
  logic [VAL_W-1:0]    val_q, val_d;
  logic [BYTE_W-1:0]   buf_q, buf_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [8:0]          rng_q, rng_d;
  logic [MAX_BINS-1:0] bins_q, bins_d;
  logic [CNT_W-1:0]    nbins_q, nbins_d;

  logic [CNT_W-1:0]    nb_clip;
  logic [VAL_W-1:0]    scaled;
  logic [3:0]          kmax, k;
  logic [RW-1:0]       rem_x;
  logic [VAL_W-1:0]    lv [NL+1];
  logic [NL-1:0]       lb;

  assign nb_clip = (req_nbins > CNT_W'(MAX_BINS))
                 ? CNT_W'(MAX_BINS) : req_nbins;
  assign scaled  = {rng_q, {SCALE_SHIFT{1'b0}}};
  assign rem_x   = RW'(rem_q);
  assign lv[0]   = val_q;

  // With s = 0x8000 a lane reduces to copying the shifted-out MSB.
  for (genvar i = 0; i < NL; i++) begin : g_lane
    bypass_lane u_lane (
      .val_i   (lv[i]),
      .bit_i   (buf_q[BYTE_W-1-i]),
      .scaled_i(scaled),
      .bin_o   (lb[i]),
      .val_o   (lv[i+1])
    );
  end

  always_comb begin
    kmax = 4'(BINS_PER_CYCLE);
`ifdef BYPASS_ALIGNED_EN
    if (rng_q == 9'd256) kmax = 4'(BYTE_W);
`endif
    k = kmax;
    if (rem_x < RW'(k)) k = 4'(rem_x);
    if (cnt_q < k) k = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (req_valid)
          state_d = (nb_clip == '0) ? DONE : DECODE;
      DECODE:
        if (cnt_q != 4'd0 && rem_q == CNT_W'(k))
          state_d = DONE;
      DONE:
        if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    bs_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    req_ready = !rst;
      DECODE:  bs_ready  = (cnt_q == 4'd0);
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Init lands before the request so a same-cycle request sees it.
  always_comb begin
    val_d   = val_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    rng_d   = rng_q;
    bins_d  = bins_q;
    nbins_d = nbins_q;
    unique case (state_q)
      IDLE: begin
        if (init) begin
          val_d = init_value;
          buf_d = '0;
          cnt_d = 4'd0;
        end
        if (req_valid) begin
          rng_d   = m_range;
          rem_d   = nb_clip;
          nbins_d = nb_clip;
          bins_d  = '0;
        end
      end
      DECODE: begin
        if (cnt_q == 4'd0) begin
          if (bs_valid) begin
            buf_d = bs_data;
            cnt_d = 4'(BYTE_W);
          end
        end else begin
          for (int i = 0; i < NL; i++) begin
            if (4'(i) < k) begin
              bins_d = {bins_d[MAX_BINS-2:0], lb[i]};
              val_d  = lv[i+1];
            end
          end
          buf_d = buf_q << k;
          cnt_d = cnt_q - k;
          rem_d = rem_q - CNT_W'(k);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= 4'd0;
      rem_q   <= '0;
      rng_q   <= '0;
      bins_q  <= '0;
      nbins_q <= '0;
    end else begin
      val_q   <= val_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      rng_q   <= rng_d;
      bins_q  <= bins_d;
      nbins_q <= nbins_d;
    end
  end

  assign out_bins    = bins_q;
  assign out_nbins   = nbins_q;
  assign m_value_out = val_q;

endmodule

// File: tb/tb_bypass_bin_decoder_seq.sv
// Randomised bench for bypass_bin_decoder_seq against a bit-queue model.
// Directed cases pin the model; a compare process checks every DONE cycle.
module tb_bypass_bin_decoder_seq;

  localparam int MAXB = 32;
  localparam int BPC  = 4;
  localparam int CW   = $clog2(MAXB + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            init = 1'b0;
  logic [15:0]     init_value = '0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [CW-1:0]   req_nbins = '0;
  logic [8:0]      m_range = 9'd256;
  logic            bs_valid = 1'b0;
  logic [7:0]      bs_data = '0;
  logic            bs_ready;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [MAXB-1:0] out_bins;
  logic [CW-1:0]   out_nbins;
  logic [15:0]     m_value_out;

  bypass_bin_decoder_seq #(
    .MAX_BINS      (MAXB),
    .BINS_PER_CYCLE(BPC),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .init_value (init_value),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_nbins  (req_nbins),
    .m_range    (m_range),
    .bs_valid   (bs_valid),
    .bs_data    (bs_data),
    .bs_ready   (bs_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bins   (out_bins),
    .out_nbins  (out_nbins),
    .m_value_out(m_value_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Byte stream shared by the source and the model, plus model state.
  logic [7:0]      stream [4096];
  int              src_idx = 0;
  int              mdl_idx = 0;
  logic [15:0]     mval = '0;
  bit              lq [$];
  logic [MAXB-1:0] exp_bins;
  logic [CW-1:0]   exp_n;
  logic [15:0]     exp_val;
  bit              have_exp = 0;
  bit              busy = 0;
  bit              stall = 0;
  int              last_cycles;
  logic [MAXB-1:0] got_bins;
  logic [CW-1:0]   got_n;
  logic [15:0]     got_val;

  function automatic bit next_bit();
    logic [7:0] b;
    if (lq.size() == 0) begin
      b = stream[mdl_idx];
      mdl_idx++;
      for (int j = 7; j >= 0; j--) lq.push_back(b[j]);
    end
    return lq.pop_front();
  endfunction

  task automatic model_req(input int n, input int rng);
    int nn;
    logic [16:0] v;
    logic [16:0] s;
    nn = (n > MAXB) ? MAXB : n;
    s = 17'(rng * 128);
    exp_bins = '0;
    for (int i = 0; i < nn; i++) begin
      v = {mval, next_bit()};
      if (v >= s) begin
        exp_bins = {exp_bins[MAXB-2:0], 1'b1};
        mval = 16'(v - s);
      end else begin
        exp_bins = {exp_bins[MAXB-2:0], 1'b0};
        mval = v[15:0];
      end
    end
    exp_n = CW'(nn);
    exp_val = mval;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      bs_valid = !stall && ($urandom_range(0, 3) != 0);
      bs_data = stream[src_idx];
    end
  end

  always @(posedge clk)
    if (bs_valid && bs_ready) src_idx <= src_idx + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          if (!have_exp) begin
            checks++;
            errors++;
            $display("FAIL spurious_out_valid: got 1 expected 0");
          end else begin
            chk("out_bins", out_bins, exp_bins);
            chk("out_nbins", out_nbins, exp_n);
            chk("m_value_out", m_value_out, exp_val);
            chk("req_ready_in_done", req_ready, 0);
          end
        end
        if (!busy || out_valid)
          chk("bs_ready_outside_decode", bs_ready, 0);
      end
    end
  end

  task automatic run_req(input int n, input int rng, input bit do_init,
                         input logic [15:0] iv, input int hold,
                         input int stall_at);
    int c;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    init = do_init;
    init_value = iv;
    req_valid = 1'b1;
    req_nbins = CW'(n);
    m_range = 9'(rng);
    if (do_init) begin
      mval = iv;
      lq.delete();
    end
    model_req(n, rng);
    have_exp = 1;
    busy = 1;
    @(negedge clk);
    init = 1'b0;
    req_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 400) begin
      if (c == stall_at) stall = 1;
      if (c == stall_at + 5) stall = 0;
      @(negedge clk);
      c++;
    end
    stall = 0;
    last_cycles = c;
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got 0 expected 1 n=%0d", n);
      have_exp = 0;
      busy = 0;
      return;
    end
    got_bins = out_bins;
    got_n = out_nbins;
    got_val = m_value_out;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    have_exp = 0;
    busy = 0;
    chk("back_to_idle", out_valid, 0);
  endtask

  initial begin
    int n;
    int rng;
    for (int i = 0; i < 4096; i++) stream[i] = 8'($urandom);

    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_bs_ready", bs_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bins", out_bins, 0);
    chk("rst_out_nbins", out_nbins, 0);
    chk("rst_m_value", m_value_out, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);

    stream[src_idx] = 8'h80;
    run_req(1, 300, 1, 16'h4B00, 0, -1);
    chk("t1_bins", got_bins, 1);
    chk("t1_nbins", got_n, 1);
    chk("t1_mval", got_val, 16'h0001);

    run_req(4, 300, 0, 16'h0, 0, -1);
    chk("lat_buffered_4", last_cycles, 1);

    stream[src_idx] = 8'h00;
    run_req(4, 256, 1, 16'h7FFF, 0, -1);
    chk("t2_bins", got_bins, 4'b1111);
    chk("t2_mval", got_val, 16'h7FF0);

    run_req(0, 400, 0, 16'h0, 0, -1);
    chk("n0_latency", last_cycles, 0);
    chk("n0_bins", got_bins, 0);
    chk("n0_mval", got_val, 16'h7FF0);

    run_req(12, 345, 1, 16'h1234, 0, 2);
    run_req(12, 345, 0, 16'h0, 3, -1);
    run_req(45, 280, 0, 16'h0, 0, -1);
    chk("clip_nbins", got_n, MAXB);

    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 40);
      rng = ($urandom_range(0, 3) == 0) ? 256 : $urandom_range(256, 510);
      run_req(n, rng, $urandom_range(0, 4) == 0,
              16'($urandom_range(0, rng * 128 - 1)),
              $urandom_range(0, 2),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1);
    end

    @(negedge clk);
    req_valid = 1'b1;
    req_nbins = CW'(20);
    m_range = 9'd333;
    busy = 1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    busy = 0;
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_bs_ready", bs_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_bins", out_bins, 0);
    chk("midrst_out_nbins", out_nbins, 0);
    chk("midrst_m_value", m_value_out, 0);
    @(negedge clk);
    rst = 1'b0;
    mval = '0;
    lq.delete();
    mdl_idx = src_idx;
    run_req(9, 300, 1, 16'h2A5C, 0, -1);
    run_req(17, 256, 0, 16'h0, 1, -1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
